voice_allocator: RTL

Polyphonic voice allocator for the tiny-synth audio path. Accepts a serial stream of note-on/note-off events and distributes them over up to 12 voice slots, driving per-voice gate, note and retrigger signals into the oscillator/envelope channels whose outputs feed the multi-channel mixer. When all voices are busy, a note-on steals the oldest voice.

---
 rtl/voice_allocator_pkg.sv | 21 ++
 rtl/voice_allocator_if.sv | 12 +
 rtl/voice_allocator_slot.sv | 55 +++++
 rtl/voice_allocator.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the tiny-synth voice allocator.
// The FSM encodings, event polarities and the voice ceiling live here.
package voice_allocator_pkg;

    localparam int MAX_VOICES = 12;

    localparam logic EV_NOTE_OFF = 1'b0;
    localparam logic EV_NOTE_ON  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Age-rank / scan-index width; never narrower than one bit.
    function automatic int rank_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note event stream into the allocator: valid/ready plus the event fields.
interface voice_allocator_if #(
    parameter int NOTE_BITS = 7
);
    logic                 ev_valid;
    logic                 ev_ready;
    logic                 ev_note_on;
    logic [NOTE_BITS-1:0] ev_note;

    modport master (output ev_valid, ev_note_on, ev_note, input ev_ready);
    modport slave  (input ev_valid, ev_note_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator_slot.sv
// One voice slot: gate, note, age rank and the one-cycle trigger pulse.
// At most one of load/retrig/release/age is asserted in any cycle.
module voice_slot #(
    parameter int NOTE_BITS = 7,
    parameter int RANK_BITS = 4,
    parameter int MAX_RANK  = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_retrig,
    input  logic                 i_release,
    input  logic                 i_age,
    input  logic [NOTE_BITS-1:0] i_note,
    output logic                 o_gate,
    output logic [NOTE_BITS-1:0] o_note,
    output logic [RANK_BITS-1:0] o_rank,
    output logic                 o_trigger
);
    localparam logic [RANK_BITS-1:0] RANK_SAT = RANK_BITS'(MAX_RANK);

    logic                 r_gate;
    logic [NOTE_BITS-1:0] r_note;
    logic [RANK_BITS-1:0] r_rank;
    logic                 r_trig;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gate <= 1'b0;
            r_note <= '0;
            r_rank <= '0;
            r_trig <= 1'b0;
        end else begin
            r_trig <= i_load | i_retrig;
            if (i_load) begin
                r_gate <= 1'b1;
                r_note <= i_note;
                r_rank <= '0;
            end else if (i_retrig) begin
                r_rank <= '0;
            end else if (i_release) begin
                // note and rank are kept so a later match scan sees stale data harmlessly
                r_gate <= 1'b0;
            end else if (i_age && r_rank != RANK_SAT) begin
                r_rank <= r_rank + 1'b1;
            end
        end
    end

    assign o_gate    = r_gate;
    assign o_note    = r_note;
    assign o_rank    = r_rank;
    assign o_trigger = r_trig;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serial note events are scanned one voice per
// cycle, then committed as retrigger / free-load / oldest-steal / release.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int NUM_VOICES = 12,
    parameter int NOTE_BITS  = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    voice_allocator_if.slave                  ev,
    output logic [NUM_VOICES-1:0]             voice_gate,
    output logic [NUM_VOICES*NOTE_BITS-1:0]   voice_note,
    output logic [NUM_VOICES-1:0]             voice_trigger,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_count
);
    localparam int RANK_BITS = rank_bits(NUM_VOICES);
    localparam int CNT_BITS  = $clog2(NUM_VOICES+1);
    localparam logic [RANK_BITS-1:0] LAST_IDX = RANK_BITS'(NUM_VOICES-1);

    state_e r_state, w_state_nxt;

    logic                 r_on;
    logic [NOTE_BITS-1:0] r_note;
    logic [RANK_BITS-1:0] r_idx;
    logic                 r_m_hit, r_f_hit, r_o_hit;
    logic [RANK_BITS-1:0] r_m_idx, r_f_idx, r_o_idx, r_o_rank;
    logic [CNT_BITS-1:0]  r_cnt;

    logic [NUM_VOICES-1:0][NOTE_BITS-1:0] w_note;
    logic [NUM_VOICES-1:0][RANK_BITS-1:0] w_rank;
    logic [NUM_VOICES-1:0] w_load, w_retrig, w_release, w_age, w_gate_nxt;
    logic [RANK_BITS-1:0]  w_target;
    logic [CNT_BITS-1:0]   w_cnt_nxt;
    logic                  w_accept;
    logic                  w_cur_gate;
    logic [NOTE_BITS-1:0]  w_cur_note;
    logic [RANK_BITS-1:0]  w_cur_rank;

    assign ev.ev_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept    = ev.ev_valid && ev.ev_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SCAN;
            ST_SCAN:   if (r_idx == LAST_IDX) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cur_gate = voice_gate[r_idx];
    assign w_cur_note = w_note[r_idx];
    assign w_cur_rank = w_rank[r_idx];

    // Candidates keep the first hit, so every tie resolves to the lowest index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_on     <= 1'b0;
            r_note   <= '0;
            r_idx    <= '0;
            r_m_hit  <= 1'b0;
            r_f_hit  <= 1'b0;
            r_o_hit  <= 1'b0;
            r_m_idx  <= '0;
            r_f_idx  <= '0;
            r_o_idx  <= '0;
            r_o_rank <= '0;
        end else if (w_accept) begin
            r_on    <= ev.ev_note_on;
            r_note  <= ev.ev_note;
            r_idx   <= '0;
            r_m_hit <= 1'b0;
            r_f_hit <= 1'b0;
            r_o_hit <= 1'b0;
        end else if (r_state == ST_SCAN) begin
            r_idx <= r_idx + 1'b1;
            if (w_cur_gate && w_cur_note == r_note && !r_m_hit) begin
                r_m_hit <= 1'b1;
                r_m_idx <= r_idx;
            end
            if (!w_cur_gate && !r_f_hit) begin
                r_f_hit <= 1'b1;
                r_f_idx <= r_idx;
            end
            if (w_cur_gate && (!r_o_hit || w_cur_rank > r_o_rank)) begin
                r_o_hit  <= 1'b1;
                r_o_idx  <= r_idx;
                r_o_rank <= w_cur_rank;
            end
        end
    end

    // Note-on always finds a target: with no free voice every voice is gated.
    always_comb begin
        w_load    = '0;
        w_retrig  = '0;
        w_release = '0;
        w_age     = '0;
        w_target  = r_m_hit ? r_m_idx : (r_f_hit ? r_f_idx : r_o_idx);
        if (r_state == ST_COMMIT) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_on == EV_NOTE_ON) begin
                    if (RANK_BITS'(v) == w_target) begin
                        w_retrig[v] = r_m_hit;
                        w_load[v]   = !r_m_hit;
                    end else begin
                        w_age[v] = voice_gate[v];
                    end
                end else begin
                    w_release[v] = r_m_hit && (RANK_BITS'(v) == r_m_idx);
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_gate_nxt[v] = w_load[v] | w_retrig[v] | (voice_gate[v] & ~w_release[v]);
            w_cnt_nxt     = w_cnt_nxt + CNT_BITS'(w_gate_nxt[v]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_cnt_nxt;
    end

    assign active_count = r_cnt;
    assign voice_note   = w_note;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
        voice_slot #(
            .NOTE_BITS (NOTE_BITS),
            .RANK_BITS (RANK_BITS),
            .MAX_RANK  (NUM_VOICES-1)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_load[v]),
            .i_retrig  (w_retrig[v]),
            .i_release (w_release[v]),
            .i_age     (w_age[v]),
            .i_note    (r_note),
            .o_gate    (voice_gate[v]),
            .o_note    (w_note[v]),
            .o_rank    (w_rank[v]),
            .o_trigger (voice_trigger[v])
        );
    end

endmodule
